// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin pick between two requesters; on a tie the
// requester that did not own the bus last wins.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arb2_rr.sv
// Two-master Wishbone B3 arbiter with round-robin grant held for the whole cyc.
// Optional stuck-slave watchdog enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2_rr
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o
);

  if ((DW % 8) != 0) begin : g_dw_chk
    $error("wb_arb2_rr: DW must be a multiple of 8");
  end
  if (TIMEOUT < 1) begin : g_to_chk
    $error("wb_arb2_rr: TIMEOUT must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic [1:0] req;
  logic [1:0] pick;
  logic       gnt0, gnt1;
  logic       own_cyc, own_stb;
  logic       timeout;

  assign gnt0    = (state == ST_GNT0);
  assign gnt1    = (state == ST_GNT1);
  assign own_cyc = gnt0 ? m0_cyc_i : (gnt1 ? m1_cyc_i : 1'b0);
  assign own_stb = gnt0 ? m0_stb_i : (gnt1 ? m1_stb_i : 1'b0);

`ifdef WB_ARB2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          blk0, blk1;

  // A master that timed out stays masked until it drops cyc and asks again.
  assign timeout = (gnt0 | gnt1) && (cnt == CW'(TIMEOUT));
  assign req     = {m1_cyc_i & ~blk1, m0_cyc_i & ~blk0};

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      cnt  <= '0;
      blk0 <= 1'b0;
      blk1 <= 1'b0;
    end else begin
      if ((state_nxt != state) || !own_stb || s_ack_i || s_err_i || s_rty_i)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      blk0 <= (timeout & gnt0) | (blk0 & m0_cyc_i);
      blk1 <= (timeout & gnt1) | (blk1 & m1_cyc_i);
    end
  end
`else
  assign timeout = 1'b0;
  assign req     = {m1_cyc_i, m0_cyc_i};
`endif

  wb_arb_rr_pick u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // The owner keeps the bus until it drops cyc; handover skips the idle cycle.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (pick[0])      state_nxt = ST_GNT0;
        else if (pick[1]) state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_cyc_i || timeout) begin
          last_nxt  = 1'b0;
          state_nxt = req[1] ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i || timeout) begin
          last_nxt  = 1'b1;
          state_nxt = req[0] ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
  assign s_cti_o = gnt1 ? m1_cti_i : m0_cti_i;
  assign s_bte_o = gnt1 ? m1_bte_i : m0_bte_i;
  assign s_cyc_o = own_cyc & ~timeout;
  assign s_stb_o = own_stb & ~timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = gnt0 & s_ack_i & ~timeout;
  assign m0_err_o = gnt0 & (s_err_i | timeout);
  assign m0_rty_o = gnt0 & s_rty_i & ~timeout;
  assign m1_ack_o = gnt1 & s_ack_i & ~timeout;
  assign m1_err_o = gnt1 & (s_err_i | timeout);
  assign m1_rty_o = gnt1 & s_rty_i & ~timeout;

  assign grant_o = {gnt1, gnt0};

endmodule

// File: doc/wb_arb2_rr.md
Name: wb_arb2_rr

Overview:
- Two-master, one-slave Wishbone B3 arbiter.
- Shares one wb_ram bank between the DAQ master and the DSP master. Instantiated per contended bank ahead of the bus matrix slave port.
- Round-robin grant with bus lock for the full cyc duration, so burst (cti/bte) transfers stay atomic.
- Registered grant; combinational data/handshake muxing.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles a granted strobe may wait for ack/err/rty before an error is forced (used only with the optional feature).

Ports:
- wb_clk  input  1  system clock.
- wb_rst  input  1  synchronous reset, active-low.
- m0_adr_i / m1_adr_i  input  AW  master address (m0 = DAQ, m1 = DSP).
- m0_dat_i / m1_dat_i  input  DW  master write data.
- m0_sel_i / m1_sel_i  input  DW/8  byte selects.
- m0_we_i / m1_we_i  input  1  write enable.
- m0_cyc_i / m1_cyc_i  input  1  bus request / lock.
- m0_stb_i / m1_stb_i  input  1  strobe.
- m0_cti_i / m1_cti_i  input  3  cycle type.
- m0_bte_i / m1_bte_i  input  2  burst type.
- m0_dat_o / m1_dat_o  output  DW  read data.
- m0_ack_o / m1_ack_o  output  1  acknowledge.
- m0_err_o / m1_err_o  output  1  error.
- m0_rty_o / m1_rty_o  output  1  retry.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  output  AW/DW/DW/8/1/1/1/3/2  slave request bus.
- s_dat_i, s_ack_i, s_err_i, s_rty_i  input  DW/1/1/1  slave response.
- grant_o  output  2  one-hot current owner; 00 = idle.

Behaviour:
- States: IDLE, GNT0, GNT1. State register and last-owner bit (last) are updated only on the wb_clk rising edge.
- Reset (wb_rst == 0 at the edge) sets state = IDLE and last = 1, so m0 wins the first tie.
  - Outputs in reset/IDLE: grant_o = 00, s_cyc_o = 0, s_stb_o = 0, all m*_ack/err/rty = 0.
  - Reset mid-transfer aborts at that edge: slave cyc drops, no ack is forwarded afterwards.
- IDLE transitions:
  - Only m0_cyc_i → GNT0.
  - Only m1_cyc_i → GNT1.
  - Both → the master that is not last. Arbitration latency is 1 cycle: the request at edge N is granted, and the slave sees cyc, after edge N.
- GNTx, owner keeps cyc_i = 1: stay, regardless of the other request (lock; covers bursts and RMW).
- GNTx, owner drops cyc_i:
  - Other master requesting → GNTy directly (handover, no idle cycle).
  - Otherwise → IDLE.
  - In both cases last = x.
- Request mux: in GNTx, all s_* request outputs = mx_* inputs. In IDLE, s_cyc_o = s_stb_o = 0 and the other request outputs are don't-care (drive m0 values).
- Response mux:
  - s_dat_i is fanned out to both m*_dat_o unconditionally.
  - ack/err/rty reach only the granted master; the non-granted master sees 0.
- A master's stb without a grant is simply held off; no error is raised.
- s_cyc_o/s_stb_o are combinational from state and owner cyc/stb. No added latency inside a granted cycle; the ack path is purely combinational.
- Width rule: sel width = DW/8. DW must be a multiple of 8; an elaboration check fails otherwise.

Optional Feature:
- Macro: WB_ARB2_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter clears on every edge where grant changes, stb is low, or any of ack/err/rty is returned. Otherwise it increments while owner stb = 1.
  - At count == TIMEOUT, the owner gets err_o = 1 for exactly one cycle and s_cyc_o/s_stb_o are forced to 0 that cycle.
  - The arbiter then moves to the other master if it is requesting, else IDLE, with last = owner.
  - The owner must re-request to regain the bus.
- Without the macro: no counter; a hung slave holds the grant indefinitely.

Decomposition:
- Package wb_arb_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2;
  - CTI constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111 (for bench checks).
- One natural sub-module: wb_arb_rr_pick, a combinational round-robin pick from (req[1:0], last), returning a one-hot grant. The top file holds the FSM, muxes and optional timeout.

Test Plan:
- Reset release, both cyc = 0 → grant_o = 00, s_cyc_o = 0 for 10 cycles. Then m0 write to adr 0x10 data 0xA5A5A5A5 → grant_o = 01 one cycle after request; m0_ack_o pulses; read-back returns 0xA5A5A5A5.
- m0 and m1 both raise cyc at the same edge after reset → m0 granted first. m0 drops cyc; with m1 still requesting, grant_o goes 01 → 10 at the next edge with no idle cycle.
- m1 holds a 4-beat incrementing burst (cti 010, 010, 010, 111) while m0 requests → m0 stays blocked until m1 cyc drops; m1_ack_o count = 4, m0_ack_o = 0 throughout.
- Slave asserts err on an m1 access while m0 is idle → m1_err_o = 1 and m0_err_o = 0. Also the alternation check: both request continuously with 1-cycle transfers → grants alternate 01, 10, 01, 10.
- Reset asserted (wb_rst = 0) mid m0 transfer before ack → at that edge s_cyc_o = 0, grant_o = 00, and no m0_ack_o is produced afterwards.
- WB_ARB2_TIMEOUT_EN defined, TIMEOUT = 15, slave never acks → m0_err_o = 1 exactly once, 15 cycles after stb; grant_o then moves to m1 if it is requesting, else 00.
